regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regwb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// Write-back arbiter: round-robin selection among ALU, LSU and MDU results into one
// register-file write port, plus a busy scoreboard of destinations with pending writes.
module regwb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_rd,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  input  logic        flush,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] busy
);

  logic [1:0]  rr_ptr_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic [31:0] busy_r;

  logic [2:0]  grant_s;
  logic [2:0]  ready_s;
  logic        hs_s;
  logic [1:0]  gidx_s;
  logic [1:0]  ptr_next_s;
  logic [4:0]  sel_rd_s;
  logic [31:0] sel_data_s;
  logic [31:0] busy_set_s;
  logic [31:0] busy_clr_s;
  logic [31:0] busy_next_s;

  // Search starts at ptr and walks upward with wrap; an out-of-range ptr behaves as 0.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] valid);
    logic [2:0] g;
    g = 3'b000;
    case (ptr)
      2'd1: begin
        if (valid[1])      g = 3'b010;
        else if (valid[2]) g = 3'b100;
        else if (valid[0]) g = 3'b001;
        else               g = 3'b000;
      end
      2'd2: begin
        if (valid[2])      g = 3'b100;
        else if (valid[0]) g = 3'b001;
        else if (valid[1]) g = 3'b010;
        else               g = 3'b000;
      end
      default: begin
        if (valid[0])      g = 3'b001;
        else if (valid[1]) g = 3'b010;
        else if (valid[2]) g = 3'b100;
        else               g = 3'b000;
      end
    endcase
    return g;
  endfunction

  // One-hot mask for a register index; x0 never produces a bit.
  function automatic logic [31:0] reg_mask(input logic en, input logic [4:0] rd);
    logic [31:0] m;
    m = 32'h0000_0000;
    if (en && (rd != 5'd0)) m = 32'h0000_0001 << rd;
    else                    m = 32'h0000_0000;
    return m;
  endfunction

  // Grant selection depends only on valid bits and the rotation pointer.
  always_comb begin
    grant_s = rr_pick(rr_ptr_r, req_valid);
    if (rst_n) ready_s = grant_s;
    else       ready_s = 3'b000;
  end

  assign req_ready = ready_s;
  assign hs_s      = |(req_valid & ready_s);

  // Decode the granted requester and pick its destination and data.
  always_comb begin
    gidx_s     = 2'd0;
    ptr_next_s = 2'd1;
    sel_rd_s   = 5'd0;
    sel_data_s = 32'h0000_0000;
    case (grant_s)
      3'b010:  gidx_s = 2'd1;
      3'b100:  gidx_s = 2'd2;
      default: gidx_s = 2'd0;
    endcase
    case (gidx_s)
      2'd1: begin
        sel_rd_s   = req_rd[9:5];
        sel_data_s = req_data[63:32];
        ptr_next_s = 2'd2;
      end
      2'd2: begin
        sel_rd_s   = req_rd[14:10];
        sel_data_s = req_data[95:64];
        ptr_next_s = 2'd0;
      end
      default: begin
        sel_rd_s   = req_rd[4:0];
        sel_data_s = req_data[31:0];
        ptr_next_s = 2'd1;
      end
    endcase
  end

  // Scoreboard next state: a set beats a same-register clear, flush beats everything.
  always_comb begin
    busy_set_s = reg_mask(rsv_valid, rsv_rd);
    busy_clr_s = reg_mask(hs_s, sel_rd_s);
    if (flush) busy_next_s = 32'h0000_0000;
    else       busy_next_s = ((busy_r & ~busy_clr_s) | busy_set_s) & 32'hFFFF_FFFE;
  end

  // Pointer, write-back register and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r   <= 2'd0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'h0000_0000;
      busy_r     <= 32'h0000_0000;
    end else begin
      busy_r <= busy_next_s;
      if (hs_s) begin
        rr_ptr_r   <= ptr_next_s;
        wb_valid_r <= (sel_rd_s != 5'd0);
        wb_rd_r    <= sel_rd_s;
        wb_data_r  <= sel_data_s;
      end else begin
        rr_ptr_r   <= rr_ptr_r;
        wb_valid_r <= 1'b0;
        wb_rd_r    <= wb_rd_r;
        wb_data_r  <= wb_data_r;
      end
    end
  end

  assign wb_valid = wb_valid_r;
  assign wb_rd    = wb_rd_r;
  assign wb_data  = wb_data_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed, table-driven bench for regwb_arbiter; vectors run back to back so each
// record's expectations include the state left by the records before it.
module tb_regwb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy;

  int checks;
  int errors;

  regwb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .rsv_valid(rsv_valid),
    .rsv_rd(rsv_rd), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    logic        rsv_v;
    logic [4:0]  rsv_rd;
    logic        flush;
    logic [2:0]  exp_ready;
    logic        exp_wv;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] exp_busy;
  } vec_t;

  localparam logic [31:0] DA = 32'h1111_1111;
  localparam logic [31:0] DL = 32'h2222_2222;
  localparam logic [31:0] DM = 32'h3333_3333;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [14:0] rd,
                              input logic [95:0] d, input logic rv, input logic [4:0] rr,
                              input logic fl, input logic [2:0] er, input logic ew,
                              input logic [4:0] erd, input logic [31:0] ed,
                              input logic [31:0] eb);
    vec_t t;
    t.rst_n = r; t.valid = v; t.rd = rd; t.data = d; t.rsv_v = rv; t.rsv_rd = rr;
    t.flush = fl; t.exp_ready = er; t.exp_wv = ew; t.exp_rd = erd; t.exp_data = ed;
    t.exp_busy = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n     = t.rst_n;
    req_valid = t.valid;
    req_rd    = t.rd;
    req_data  = t.data;
    rsv_valid = t.rsv_v;
    rsv_rd    = t.rsv_rd;
    flush     = t.flush;
  endtask

  logic [31:0] prev_busy;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; req_valid = 3'b000; req_rd = 15'd0; req_data = 96'd0;
    rsv_valid = 1'b0; rsv_rd = 5'd0; flush = 1'b0;

    vecs[0]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b001, 1'b1, 5'd1, DA, 32'h0);
    vecs[2]  = mk(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b010, 1'b1, 5'd2, DL, 32'h0);
    vecs[3]  = mk(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b100, 1'b1, 5'd3, DM, 32'h0);
    vecs[4]  = mk(1'b1, 3'b110, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b010, 1'b1, 5'd2, DL, 32'h0);
    vecs[5]  = mk(1'b1, 3'b110, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b100, 1'b1, 5'd3, DM, 32'h0);
    vecs[6]  = mk(1'b1, 3'b110, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b010, 1'b1, 5'd2, DL, 32'h0);
    vecs[7]  = mk(1'b1, 3'b110, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b100, 1'b1, 5'd3, DM, 32'h0);
    vecs[8]  = mk(1'b1, 3'b000, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b000, 1'b0, 5'd3, DM, 32'h0);
    vecs[9]  = mk(1'b1, 3'b000, 15'd0, 96'd0, 1'b1, 5'd4, 1'b0,
                  3'b000, 1'b0, 5'd3, DM, 32'h0000_0010);
    vecs[10] = mk(1'b1, 3'b001, 15'd0, {64'd0, 32'hDEAD_BEEF}, 1'b0, 5'd0, 1'b0,
                  3'b001, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0000_0010);
    vecs[11] = mk(1'b1, 3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 1'b0,
                  3'b000, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0000_0030);
    vecs[12] = mk(1'b1, 3'b100, {5'd5, 10'd0}, {32'h1234_5678, 64'd0}, 1'b0, 5'd0, 1'b0,
                  3'b100, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_0010);
    vecs[13] = mk(1'b1, 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h7777_7777, 32'd0}, 1'b1, 5'd7, 1'b0,
                  3'b010, 1'b1, 5'd7, 32'h7777_7777, 32'h0000_0090);
    vecs[14] = mk(1'b1, 3'b001, {10'd0, 5'd4}, {64'd0, 32'h4444_4444}, 1'b1, 5'd8, 1'b0,
                  3'b001, 1'b1, 5'd4, 32'h4444_4444, 32'h0000_0180);
    vecs[15] = mk(1'b1, 3'b010, {5'd0, 5'd10, 5'd0}, {32'd0, 32'hAAAA_5555, 32'd0}, 1'b1, 5'd9, 1'b1,
                  3'b010, 1'b1, 5'd10, 32'hAAAA_5555, 32'h0);
    vecs[16] = mk(1'b1, 3'b100, {5'd6, 10'd0}, {32'h6666_6666, 64'd0}, 1'b1, 5'd11, 1'b0,
                  3'b100, 1'b1, 5'd6, 32'h6666_6666, 32'h0000_0800);
    vecs[17] = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
    vecs[18] = mk(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {DM, DL, DA}, 1'b0, 5'd0, 1'b0,
                  3'b001, 1'b1, 5'd1, DA, 32'h0);

    prev_busy = 32'h0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d req_ready", i), {29'd0, req_ready}, {29'd0, vecs[i].exp_ready});
      // busy must not move before the edge, whatever rsv/handshake are doing
      if (i > 0) check($sformatf("v%0d busy_pre", i), busy, prev_busy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].exp_wv});
      check($sformatf("v%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].exp_rd});
      check($sformatf("v%0d wb_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
      prev_busy = vecs[i].exp_busy;
    end

    // Idle cycles: pointer (now 1) and wb_rd/wb_data must hold, wb_valid low.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      check("idle req_ready", {29'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("idle wb_valid", {31'd0, wb_valid}, 32'd0);
      check("idle wb_rd", {27'd0, wb_rd}, 32'd1);
      check("idle wb_data", wb_data, DA);
    end

    // ALU and MDU pending with pointer at 1: MDU wins; changing rd/data must not move the grant.
    @(negedge clk);
    req_valid = 3'b101;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {DM, DL, DA};
    #1;
    check("held ptr req_ready", {29'd0, req_ready}, 32'h4);
    req_rd   = {5'd17, 5'd0, 5'd0};
    req_data = {32'hCAFE_F00D, 64'd0};
    #1;
    check("data indep req_ready", {29'd0, req_ready}, 32'h4);
    @(posedge clk);
    #1;
    check("held ptr wb_rd", {27'd0, wb_rd}, 32'd17);
    check("held ptr wb_data", wb_data, 32'hCAFE_F00D);
    check("held ptr wb_valid", {31'd0, wb_valid}, 32'd1);

    // Pointer wrapped to 0: ALU is next.
    @(negedge clk);
    #1;
    check("wrap req_ready", {29'd0, req_ready}, 32'h1);
    req_valid = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
